// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared state encoding and default parameters for core_run_sequencer
package core_seq_pkg;
  typedef enum logic [2:0] {IDLE, HOLD, REQ, RUN, REPORT} run_state_e;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_RST_CYC = 2;
  localparam int DEF_MAX_CYC = 1024;
endpackage

// File: rtl/core_run_sequencer.sv
// core_run_sequencer: holds the core in reset, pulses req, times the run until done or MAX_CYC, reports to host
// ports: clk; reset (async, active-low); start/ack host handshake; busy, rslt_valid, cycles, timeout to host;
//        core_reset, core_req to core; core_done from core
module core_run_sequencer
  import core_seq_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int MAX_CYC = DEF_MAX_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             rslt_valid,
  output logic [CNT_W-1:0] cycles,
  output logic             timeout,
  output logic             core_reset,
  output logic             core_req,
  input  logic             core_done
);
  localparam int HW = $clog2(RST_CYC + 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] MAX       = CNT_W'(MAX_CYC);
  run_state_e       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (start) begin
          to_d    = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        hold_d  = (hold_q == HOLD_LAST) ? '0 : hold_q + HW'(1);
        state_d = (hold_q == HOLD_LAST) ? REQ : HOLD;
      end
      REQ: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // saturate so a mis-set MAX_CYC can never wrap the reported count
        cnt_d = (cnt_q == MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (core_done) begin
          state_d = REPORT;
          to_d    = 1'b0;
        end else if (cnt_q + CNT_W'(1) == MAX) begin
          state_d = REPORT;
          to_d    = 1'b1;
        end
      end
      REPORT: state_d = ack ? IDLE : REPORT;
      default: state_d = IDLE;
    endcase
  end
  // core_reset decodes from state, so it rises combinationally when reset forces IDLE
  assign busy       = (state_q == HOLD) || (state_q == REQ) || (state_q == RUN);
  assign rslt_valid = (state_q == REPORT);
  assign core_reset = (state_q == IDLE) || (state_q == HOLD);
  assign core_req   = (state_q == REQ);
  assign cycles     = cnt_q;
  assign timeout    = to_q;
endmodule

// File: tb/tb_core_run_sequencer.sv
// tb_core_run_sequencer: randomized run sequences checked against a run-level result model
module tb_core_run_sequencer;
  localparam int CNT_W = 16, RST_CYC = 2, MAX_CYC = 8;
  logic clk = 0, reset = 0, start = 0, ack = 0, core_done = 0;
  logic busy, rslt_valid, timeout, core_reset, core_req;
  logic [CNT_W-1:0] cycles;
  int n_cmp = 0, n_err = 0;
  int exp_cyc = 0;
  bit exp_to = 0;
  core_run_sequencer #(.CNT_W(CNT_W), .RST_CYC(RST_CYC), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack), .busy(busy),
    .rslt_valid(rslt_valid), .cycles(cycles), .timeout(timeout),
    .core_reset(core_reset), .core_req(core_req), .core_done(core_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, ".core_reset"}, core_reset, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".rslt_valid"}, rslt_valid, 0);
    chk({tag, ".core_req"}, core_req, 0);
    chk({tag, ".cycles"}, cycles, exp_cyc);
    chk({tag, ".timeout"}, timeout, exp_to);
  endtask
  // Starts at a negedge in IDLE. done_at = first RUN cycle with core_done=1.
  task automatic run(input int done_at, input bit stuck, input bit noise, input int rpt_wait);
    int len;
    bit to;
    len = (done_at < MAX_CYC) ? done_at : MAX_CYC;
    to  = done_at > MAX_CYC;
    chk_idle("pre");
    start = 1;
    core_done = stuck;
    for (int i = 0; i < RST_CYC; i++) begin
      @(negedge clk);
      start = noise & $urandom_range(0, 1);
      chk("hold.core_reset", core_reset, 1);
      chk("hold.busy", busy, 1);
      chk("hold.core_req", core_req, 0);
      chk("hold.cycles", cycles, exp_cyc);
      chk("hold.timeout", timeout, 0);
    end
    @(negedge clk);
    chk("req.core_req", core_req, 1);
    chk("req.core_reset", core_reset, 0);
    chk("req.busy", busy, 1);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      start = noise & $urandom_range(0, 1);
      core_done = (k >= done_at);
      chk("run.busy", busy, 1);
      chk("run.core_req", core_req, 0);
      chk("run.core_reset", core_reset, 0);
      chk("run.cycles", cycles, k - 1);
    end
    exp_cyc = len;
    exp_to  = to;
    for (int w = 0; w <= rpt_wait; w++) begin
      @(negedge clk);
      core_done = stuck;
      start = noise & $urandom_range(0, 1);
      chk("rpt.rslt_valid", rslt_valid, 1);
      chk("rpt.busy", busy, 0);
      chk("rpt.core_reset", core_reset, 0);
      chk("rpt.cycles", cycles, exp_cyc);
      chk("rpt.timeout", timeout, exp_to);
    end
    ack = 1;
    @(negedge clk);
    ack = 0;
    start = 0;
    core_done = 0;
    chk_idle("post");
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk_idle("reset");
    repeat (3) @(negedge clk);
    chk_idle("idle_wait");
    run(5, 0, 0, 0);
    run(100, 0, 0, 1);
    run(8, 0, 0, 0);
    run(1, 1, 0, 2);
    run(3, 0, 1, 3);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk_idle("stray_ack");
    run(100, 0, 0, 0);
    start = 1;
    for (int i = 0; i < RST_CYC + 1 + 2; i++) begin
      @(negedge clk);
      start = 0;
    end
    chk("mid.busy_before", busy, 1);
    reset = 0;
    #1;
    exp_cyc = 0;
    exp_to  = 0;
    chk("mid.core_reset", core_reset, 1);
    chk("mid.busy", busy, 0);
    chk("mid.rslt_valid", rslt_valid, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk_idle("after_mid");
    run(4, 0, 0, 0);
    for (int r = 0; r < 25; r++)
      run($urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
